// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage core: opcodes, instruction field positions and the NOP word.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OP_W    = 6;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    // Instructions that read rt as a source operand in ID.
    function automatic logic op_uses_rt(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != CNT_MAX)) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use hazard detection, branch/jump flush
// and saturating stall/flush performance counters.
module if_id_hazard
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      pc_i,
    input  logic             flush_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    output logic [31:0]      instr_o,
    output logic [31:0]      pc_o,
    output logic             valid_o,
    output logic             pc_write_o,
    output logic             ctrl_zero_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        pc_q;
    logic               valid_q;

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rt;
    logic             hazard;
    logic             stall_inc;
    logic             flush_inc;

    // Load-use compare against the instruction sitting in ID; r0 never stalls.
    always_comb begin
        op      = instr_q[OP_MSB:OP_LSB];
        rs      = instr_q[RS_MSB:RS_LSB];
        rt      = instr_q[RT_MSB:RT_LSB];
        uses_rt = op_uses_rt(op);
        hazard  = valid_q && ex_memread_i && (ex_rt_i != 5'd0) &&
                  ((ex_rt_i == rs) || (uses_rt && (ex_rt_i == rt)));
    end

    assign pc_write_o  = !hazard;
    assign ctrl_zero_o = hazard || !valid_q;

    // A stall wins over flush: the branch in ID must re-resolve with fresh operands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (hazard) begin
            instr_q <= instr_q;
            pc_q    <= pc_q;
            valid_q <= valid_q;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= pc_i;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

    assign stall_inc = hazard;
    assign flush_inc = flush_i && !hazard;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: doc/if_id_hazard.md
Name: if_id_hazard

Overview:
- IF/ID pipeline register with integrated load-use hazard detection for the 5-stage MIPS-style core.
- Sits between instruction fetch and decode. Drives the decode inputs, the PC write-enable, and the bubble-select that zeroes WB/M/EX control before it enters ID_EX.
- Consumes the registered MemRead flag (HD) and RT address of the ID_EX stage.
- Handles branch/jump flush and keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- NOP_INSTR, 32'h0000_0000, instruction word loaded on reset and on flush.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- instr_i  input  32  fetched instruction from instruction memory.
- pc_i  input  32  PC+4 of the fetched instruction.
- flush_i  input  1  branch taken or jump resolved in ID; discard the fetched instruction.
- ex_memread_i  input  1  MemRead (HD) of the instruction currently in ID_EX.
- ex_rt_i  input  5  RT address of the instruction currently in ID_EX.
- instr_o  output  32  registered instruction to decode.
- pc_o  output  32  registered PC+4 to decode and branch adder.
- valid_o  output  1  registered instruction is real, not a bubble.
- pc_write_o  output  1  PC register and IF_ID may load this cycle.
- ctrl_zero_o  output  1  force WB/M/EX control into ID_EX to zero.
- stall_cnt_o  output  CNT_W  count of load-use stall cycles.
- flush_cnt_o  output  CNT_W  count of flush cycles.

Behaviour:
- Reset (rst_i=1 at an edge) sets:
  - instr_q=NOP_INSTR, pc_q=0, valid_q=0.
  - Both counters to 0.
  - Reset dominates every other input, including a reset taken mid-stall.
- Decoded fields of instr_q: rs=[25:21], rt=[20:16], op=[31:26].
- uses_rt=1 when op is 6'h00 (R-type), 6'h04 (beq) or 6'h2B (sw); otherwise uses_rt=0.
- hazard (combinational) = valid_q && ex_memread_i && ex_rt_i!=0 && (ex_rt_i==rs || (uses_rt && ex_rt_i==rt)).
- Combinational outputs:
  - pc_write_o = !hazard.
  - ctrl_zero_o = hazard || !valid_q.
  - instr_o, pc_o and valid_o come directly from the registers, so they have zero combinational path from the *_i inputs.
- Register update priority at each edge when rst_i=0:
  1. hazard=1: hold instr_q, pc_q and valid_q. flush_i is ignored, because the branch in ID has stale operands and must re-evaluate. stall_cnt increments.
  2. else flush_i=1: instr_q=NOP_INSTR, pc_q=pc_i, valid_q=0. flush_cnt increments.
  3. else: instr_q=instr_i, pc_q=pc_i, valid_q=1.
- Latency: one cycle from instr_i to instr_o.
- A load-use stall lasts exactly one cycle. During the stall, ID_EX receives a bubble; next cycle the load has moved to EX_MEM, so hazard deasserts.
- Counters saturate at all-ones and never wrap.
- Writes to r0 never stall: ex_rt_i==0 is excluded.
- A flush the cycle after a stall is taken normally.
- Back-to-back flushes keep valid_q=0 and each one counts.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_SW=6'h2B, OP_LW=6'h23.
  - field index constants RS_MSB/LSB and RT_MSB/LSB.
  - NOP word.
- One sub-module, sat_counter (parameterized width, synchronous reset, increment enable, saturating). It is instantiated twice, for stall and flush.
- Hazard compare stays inline.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with instr_i=32'hFFFF_FFFF -> instr_o=0, pc_o=0, valid_o=0, ctrl_zero_o=1, pc_write_o=1, both counters 0.
- Load-use on rs:
  - Stimulus: IF_ID holds add $3,$2,$4 (32'h0044_1820); ex_memread_i=1, ex_rt_i=2.
  - Response: pc_write_o=0, ctrl_zero_o=1, instr_o held one cycle, stall_cnt_o=1.
  - Next cycle, with ex_memread_i=0: pc_write_o=1 and the new instr_i is loaded.
- rt filtering:
  - addi $5,$6,1 (op 6'h08) with ex_rt_i=5 and ex_memread_i=1 -> no stall.
  - Same check with sw $5,0($6) -> stall.
  - ex_rt_i=0 with rs=0 -> no stall.
- Flush: flush_i=1 with instr_i=32'h1234_5678, pc_i=32'h40 -> next cycle instr_o=0, valid_o=0, pc_o=32'h40, ctrl_zero_o=1, flush_cnt_o=1.
- Simultaneous hazard and flush_i=1 -> hold, flush ignored, stall_cnt_o increments, flush_cnt_o unchanged. Then the flush is honoured on the following cycle.
- Saturation and reset mid-stall:
  - Run with CNT_W=2 and 5 stall cycles -> stall_cnt_o=3.
  - Assert rst_i during a stall -> valid_o=0 and counters 0 on the next edge.
